// File: rtl/arp_ctrl.sv
// ARP command controller: turns received requests into replies, issues user requests with
// timed retry, caches the resolved peer and spaces frames. Optional macro: ARP_REFRESH_EN.
module arp_ctrl #(
    parameter int unsigned RETRY_CYCLES = 125_000_000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned IFG_CYCLES   = 12,
    parameter int unsigned TX_TIMEOUT   = 4096
`ifdef ARP_REFRESH_EN
   ,parameter int unsigned REFRESH_CYCLES = 1_250_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        req_trig,
    input  logic [31:0] req_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic [31:0] resolved_ip,
    output logic        busy,
    output logic        retry_fail
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

    localparam int unsigned RTW = (RETRY_CYCLES > 4) ? $clog2(RETRY_CYCLES) : 2;
    localparam int unsigned WDW = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
    localparam int unsigned GW  = (IFG_CYCLES > 4) ? $clog2(IFG_CYCLES) : 2;
    localparam int unsigned RCW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    // The IDLE->SEND hop and the pending-flag register add two cycles of latency, so the
    // GAP and retry counters stop three short: the launch strobe lands exactly IFG_CYCLES
    // (resp. RETRY_CYCLES) cycles after the tx_done pulse.
    localparam logic [RTW-1:0] RETRY_LAST = RTW'((RETRY_CYCLES > 3) ? RETRY_CYCLES - 3 : 0);
    localparam logic [GW-1:0]  GAP_LAST   = GW'((IFG_CYCLES > 3) ? IFG_CYCLES - 3 : 0);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(TX_TIMEOUT - 1);
    localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRY);
    localparam logic [47:0]    BCAST_MAC  = {48{1'b1}};

    state_t           state, next_state;
    logic             rep_pend, req_pend, seq_active;
    logic [47:0]      rep_mac;
    logic [31:0]      rep_ip, tgt_ip;
    logic             retry_run;
    logic [RTW-1:0]   retry_timer;
    logic [RCW-1:0]   retry_cnt;
    logic [WDW-1:0]   wd_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [1:0]       rst_hold;

    logic launch_ok, launch, rx_req, rx_match, frame_done, wd_expire;

    assign launch_ok  = (rst_hold == 2'd2);
    assign launch     = (state == IDLE) && (next_state == SEND);
    assign rx_req     = arp_rx_done && !arp_rx_type;
    assign rx_match   = arp_rx_done && arp_rx_type && seq_active && (src_ip == tgt_ip);
    assign frame_done = (state == WAIT_DONE) && tx_done;
    assign wd_expire  = (state == WAIT_DONE) && !tx_done && (wd_cnt == WD_LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (launch_ok && (rep_pend || req_pend)) next_state = SEND;
            SEND:      next_state = WAIT_DONE;
            WAIT_DONE: if (tx_done || (wd_cnt == WD_LAST)) next_state = GAP;
            GAP:       if (gap_cnt == GAP_LAST) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        arp_tx_en = (state == SEND);
        busy      = (state != IDLE) || rep_pend || req_pend;
    end

`ifdef ARP_REFRESH_EN
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
    logic [31:0] refresh_cnt;
`endif

    // NOTE: buffers and cached addresses are reset too, so every output reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_pend     <= 1'b0;
            req_pend     <= 1'b0;
            seq_active   <= 1'b0;
            rep_mac      <= '0;
            rep_ip       <= '0;
            tgt_ip       <= '0;
            retry_run    <= 1'b0;
            retry_timer  <= '0;
            retry_cnt    <= '0;
            retry_fail   <= 1'b0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            rst_hold     <= '0;
            arp_tx_type  <= 1'b0;
            des_mac      <= '0;
            des_ip       <= '0;
            resolved     <= 1'b0;
            resolved_mac <= '0;
            resolved_ip  <= '0;
`ifdef ARP_REFRESH_EN
            refresh_cnt  <= '0;
`endif
        end else begin
            if (rst_hold != 2'd2) rst_hold <= rst_hold + 2'd1;

            wd_cnt  <= (state == WAIT_DONE) ? wd_cnt + WDW'(1) : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

            // Launch: the only place the transmitter-facing fields change.
            if (launch) begin
                if (rep_pend) begin
                    rep_pend    <= 1'b0;
                    arp_tx_type <= 1'b1;
                    des_mac     <= rep_mac;
                    des_ip      <= rep_ip;
                end else begin
                    req_pend    <= 1'b0;
                    arp_tx_type <= 1'b0;
                    des_mac     <= BCAST_MAC;
                    des_ip      <= tgt_ip;
                end
            end

            // A request frame the transmitter never finished goes back in the queue.
            if (wd_expire && !arp_tx_type && seq_active) req_pend <= 1'b1;

            if (frame_done && !arp_tx_type && seq_active) begin
                retry_run   <= 1'b1;
                retry_timer <= '0;
            end else if (retry_run) begin
                if (retry_timer == RETRY_LAST) begin
                    retry_run <= 1'b0;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + RCW'(1);
                        req_pend  <= 1'b1;
                    end else begin
                        retry_fail <= 1'b1;
                        seq_active <= 1'b0;
                        resolved   <= 1'b0;
                    end
                end else begin
                    retry_timer <= retry_timer + RTW'(1);
                end
            end

`ifdef ARP_REFRESH_EN
            if (!resolved) begin
                refresh_cnt <= '0;
            end else if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                req_pend    <= 1'b1;
                retry_cnt   <= '0;
                retry_run   <= 1'b0;
                seq_active  <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end
`endif

            if (rx_req) begin
                rep_pend <= 1'b1;
                rep_mac  <= src_mac;
                rep_ip   <= src_ip;
            end

            if (rx_match) begin
                resolved     <= 1'b1;
                resolved_mac <= src_mac;
                resolved_ip  <= src_ip;
                req_pend     <= 1'b0;
                retry_run    <= 1'b0;
                seq_active   <= 1'b0;
            end

            // A new trigger restarts the whole sequence, overriding anything above.
            if (req_trig) begin
                req_pend   <= 1'b1;
                tgt_ip     <= req_ip;
                retry_cnt  <= '0;
                retry_fail <= 1'b0;
                resolved   <= 1'b0;
                retry_run  <= 1'b0;
                seq_active <= 1'b1;
            end
        end
    end

endmodule
